// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

  localparam int RX_PRESCALE_W = 5;
  localparam int RX_EDGE_W     = 6;
  localparam int RX_BIT_W      = 4;
  localparam int RX_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    CHECK  = 3'd5
  } rx_state_e;

  // States in which the edge/bit counter runs.
  function automatic logic is_counting(rx_state_e s);
    return (s == START) || (s == DATA) || (s == PARITY) || (s == STOP);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl.sv
// Receive-side frame sequencer: walks start, data, optional parity and stop
// bits using the external edge/bit counter and strobes the datapath blocks.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = RX_PRESCALE_W,
  parameter int EDGE_W     = RX_EDGE_W,
  parameter int BIT_W      = RX_BIT_W,
  parameter int DATA_BITS  = RX_DATA_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [EDGE_W-1:0]     edge_cnt,
  input  logic [BIT_W-1:0]      bit_cnt,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic                  cnt_en,
  output logic                  dat_samp_en,
  output logic                  strt_chk_en,
  output logic                  deser_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid,
  output logic                  busy
);

  // One extra bit so prescale+1 and mid+2 never overflow the compare.
  localparam int CW = EDGE_W + 1;

  rx_state_e             state;
  rx_state_e             state_next;
  logic [PRESCALE_W-1:0] pscl_q;
  logic                  par_en_q;

  logic [CW-1:0]    edge_ext;
  logic [CW-1:0]    edge_nxt;
  logic [CW-1:0]    mid_nxt;
  logic             last;
  logic             frame_start;
  logic             counting_nxt;
  logic             chk_nxt;
  logic             win_nxt;
  logic [BIT_W-1:0] stop_max;

  assign edge_ext = CW'(edge_cnt);
  assign last     = (edge_ext == CW'(pscl_q) + CW'(1));
  assign stop_max = par_en_q ? BIT_W'(DATA_BITS + 2) : BIT_W'(DATA_BITS + 1);

  // Next-state decode; rx_in only matters in IDLE and CHECK.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (!rx_in) state_next = START;
      START:  if (last) state_next = (strt_glitch || (bit_cnt != '0)) ? IDLE : DATA;
      DATA: begin
        if (last) begin
          if (bit_cnt > BIT_W'(DATA_BITS))       state_next = IDLE;
          else if (bit_cnt == BIT_W'(DATA_BITS)) state_next = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: if (last) state_next = (bit_cnt > BIT_W'(DATA_BITS + 1)) ? IDLE : STOP;
      STOP:   if (last) state_next = (bit_cnt > stop_max) ? IDLE : CHECK;
      CHECK:  state_next = rx_in ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the edge count the
  // counter will show next cycle; a strobe then coincides with edge==mid+2.
  assign frame_start  = ((state == IDLE) || (state == CHECK)) && (state_next == START);
  assign mid_nxt      = frame_start ? CW'(prescale >> 1) : CW'(pscl_q >> 1);
  assign edge_nxt     = (cnt_en && !last) ? edge_ext + CW'(1) : '0;
  assign counting_nxt = is_counting(state_next);
  assign chk_nxt      = counting_nxt && (edge_nxt == mid_nxt + CW'(2));
  assign win_nxt      = counting_nxt && (edge_nxt + CW'(1) >= mid_nxt)
                                     && (edge_nxt <= mid_nxt + CW'(1));

  // State register, frame configuration capture and Moore outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pscl_q      <= '0;
      par_en_q    <= 1'b0;
      cnt_en      <= 1'b0;
      dat_samp_en <= 1'b0;
      strt_chk_en <= 1'b0;
      deser_en    <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state <= state_next;
      if (frame_start) begin
        pscl_q   <= prescale;
        par_en_q <= par_en;
      end
      cnt_en      <= counting_nxt;
      dat_samp_en <= win_nxt;
      strt_chk_en <= chk_nxt && (state_next == START);
      deser_en    <= chk_nxt && (state_next == DATA);
      par_chk_en  <= chk_nxt && (state_next == PARITY);
      stp_chk_en  <= chk_nxt && (state_next == STOP);
      data_valid  <= (state_next == CHECK) && !stp_err && !(par_en_q && par_err);
      busy        <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: models the edge/bit counter and the three checkers
// around the DUT and compares every output cycle against frame arithmetic.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst, rx_in, par_en;
  logic [4:0] prescale;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       strt_glitch, par_err, stp_err;
  logic       cnt_en, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en;
  logic       data_valid, busy;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // Environment state: counter and checker models.
  int m_edge = 0, m_bit = 0, m_wrap = 9;
  bit prev_cnt = 0, prev_strt = 0, prev_par = 0, prev_stp = 0;
  bit v_strt = 0, v_par = 0, v_stp = 0;
  bit f_glitch = 0, f_perr = 0, f_serr = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .prescale(prescale),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .strt_glitch(strt_glitch),
    .par_err(par_err), .stp_err(stp_err), .cnt_en(cnt_en),
    .dat_samp_en(dat_samp_en), .strt_chk_en(strt_chk_en), .deser_en(deser_en),
    .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .data_valid(data_valid),
    .busy(busy)
  );

  function automatic logic [7:0] outs();
    return {cnt_en, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, busy};
  endfunction

  // Expected outputs k cycles after the first START cycle of a frame.
  function automatic logic [7:0] exp_vec(int k, int p, bit pe, bit glitch, bit good);
    int B, mid, nb, bi, e;
    bit ce, hit, bsy, dv;
    B   = p + 2;
    mid = p / 2;
    nb  = glitch ? 1 : (pe ? 11 : 10);
    bi  = k / B;
    e   = k % B;
    ce  = (k < nb * B);
    bsy = ce || (!glitch && k == nb * B);
    hit = ce && (e == mid + 2);
    dv  = !glitch && good && (k == nb * B);
    return {ce, ce && (e >= mid - 1) && (e <= mid + 1), hit && bi == 0,
            hit && bi >= 1 && bi <= 8, hit && pe && !glitch && bi == 9,
            hit && !glitch && bi == nb - 1, dv, bsy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; then update the counter/checker models for this cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
    if (prev_cnt) begin
      if (m_edge == m_wrap) begin
        m_edge = 0;
        m_bit  = (m_bit + 1) % 16;
      end else begin
        m_edge++;
      end
    end else begin
      m_edge = 0;
      m_bit  = 0;
    end
    if (!prev_cnt) begin
      v_strt = 0; v_par = 0; v_stp = 0;
    end
    if (prev_strt) v_strt = 1;
    if (prev_par)  v_par  = 1;
    if (prev_stp)  v_stp  = 1;
    edge_cnt    = 6'(m_edge);
    bit_cnt     = 4'(m_bit);
    strt_glitch = v_strt ? f_glitch : 1'($urandom);
    par_err     = v_par  ? f_perr   : 1'($urandom);
    stp_err     = v_stp  ? f_serr   : 1'($urandom);
    prev_cnt  = cnt_en;
    prev_strt = strt_chk_en;
    prev_par  = par_chk_en;
    prev_stp  = stp_chk_en;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      cyc();
      chk($sformatf("idle i=%0d", i), 32'(outs()), 32'd0);
    end
  endtask

  // Runs one frame starting from IDLE or CHECK; returns in CHECK (or IDLE after a glitch).
  task automatic frame(input int p, input bit pe, input bit glitch, input bit pbad,
                       input bit sbad, input int pchg, input int abort_k, output int dv_cyc);
    int n, ndeser, npar;
    bit good;
    n      = (glitch ? 1 : (pe ? 11 : 10)) * (p + 2);
    good   = !sbad && !(pe && pbad);
    ndeser = 0;
    npar   = 0;
    dv_cyc = -1;
    prescale = 5'(p);
    par_en   = pe;
    rx_in    = 1'b0;
    m_wrap   = p + 1;
    f_glitch = glitch;
    f_perr   = pbad;
    f_serr   = sbad;
    for (int k = 0; k <= n; k++) begin
      cyc();
      if (k == 0) begin
        if (!glitch) rx_in = 1'b1;
        if (pchg >= 0) prescale = 5'(pchg);
      end
      if (k == 1) rx_in = 1'b1;
      chk($sformatf("vec p=%0d pe=%0d g=%0d k=%0d", p, pe, glitch, k),
          32'(outs()), 32'(exp_vec(k, p, pe, glitch, good)));
      if (deser_en)   ndeser++;
      if (par_chk_en) npar++;
      if (data_valid) dv_cyc = cycle;
      if (k == abort_k) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("reset_mid_frame", 32'(outs()), 32'd0);
        return;
      end
    end
    chk("deser_count", 32'(ndeser), glitch ? 32'd0 : 32'd8);
    chk("par_chk_count", 32'(npar), (pe && !glitch) ? 32'd1 : 32'd0);
  endtask

  // Illegal prescale: only a bounded return to IDLE is required.
  task automatic illegal(input int p);
    int t;
    prescale = 5'(p);
    par_en   = 1'b0;
    rx_in    = 1'b0;
    m_wrap   = p + 1;
    f_glitch = 0; f_perr = 0; f_serr = 0;
    cyc();
    rx_in = 1'b1;
    t = 0;
    while (busy && t < 12 * (p + 2) + 8) begin
      cyc();
      t++;
    end
    chk($sformatf("illegal_return p=%0d", p), 32'(busy), 32'd0);
  endtask

  initial begin
    int d1, d2, p;
    bit pe, g, pb, sb;
    rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; prescale = 5'd8;
    edge_cnt = '0; bit_cnt = '0; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    repeat (3) cyc();
    chk("reset_state", 32'(outs()), 32'd0);
    rst = 1'b0;
    idle(3);

    // Clean frame, no parity.
    frame(8, 0, 0, 0, 0, -1, -1, d1);
    idle(4);
    // Parity frame good, then parity error.
    frame(8, 1, 0, 0, 0, -1, -1, d1);
    idle(2);
    frame(8, 1, 0, 1, 0, -1, -1, d1);
    chk("par_err_no_valid", 32'(d1), 32'hFFFF_FFFF);
    idle(2);
    // Start glitch.
    frame(8, 0, 1, 0, 0, -1, -1, d1);
    idle(3);
    // Back-to-back frames.
    frame(8, 0, 0, 0, 0, -1, -1, d1);
    frame(8, 0, 0, 0, 0, -1, -1, d2);
    chk("b2b_spacing", 32'(d2 - d1), 32'(10 * (8 + 2) + 1));
    idle(3);
    // Reset in DATA with bit_cnt==4, then a clean frame.
    frame(8, 0, 0, 0, 0, -1, 4 * 10 + 3, d1);
    idle(4);
    frame(8, 0, 0, 0, 0, -1, -1, d1);
    idle(2);
    // Prescale change mid-frame, then a frame at the new prescale.
    frame(8, 0, 0, 0, 0, 16, -1, d1);
    idle(2);
    frame(16, 0, 0, 0, 0, -1, -1, d1);
    idle(2);
    // Stop error.
    frame(8, 0, 0, 0, 1, -1, -1, d1);
    idle(2);

    // Randomised frames, some back-to-back.
    for (int i = 0; i < 12; i++) begin
      p  = 2 * $urandom_range(2, 15);
      pe = 1'($urandom);
      g  = ($urandom_range(0, 5) == 0);
      pb = 1'($urandom);
      sb = ($urandom_range(0, 3) == 0);
      frame(p, pe, g, pb, sb, -1, -1, d1);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 4));
    end
    idle(2);

    illegal(3);
    idle(2);
    illegal(1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART RX path.
- Drives the enable of the edge/bit counter and watches its edge_cnt/bit_cnt outputs to walk through one frame: start, 8 data bits, optional parity, stop.
- Issues single-cycle strobes to the sampler, deserializer and the start/parity/stop checkers.
- Raises data_valid for one cycle when a frame passes all checks.
- Sits between the synchronized rx line and the RX datapath sub-blocks.

Parameters:
- PRESCALE_W, 5, width of prescale input.
- EDGE_W, 6, width of edge_cnt input.
- BIT_W, 4, width of bit_cnt input.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- rx_in  in  1  serial line; already synchronized upstream; idle high.
- par_en  in  1  1 = frame carries a parity bit.
- prescale  in  PRESCALE_W  oversampling config; legal values even, 4..30.
- edge_cnt  in  EDGE_W  from edge/bit counter.
- bit_cnt  in  BIT_W  from edge/bit counter.
- strt_glitch  in  1  start checker result; valid from the cycle after strt_chk_en until the counter is disabled.
- par_err  in  1  parity checker result; same validity rule relative to par_chk_en.
- stp_err  in  1  stop checker result; same validity rule relative to stp_chk_en.
- cnt_en  out  1  enable to the edge/bit counter; 0 clears the counter.
- dat_samp_en  out  1  sampler window enable.
- strt_chk_en  out  1  one-cycle start-check strobe.
- deser_en  out  1  one-cycle shift strobe to the deserializer.
- par_chk_en  out  1  one-cycle parity-check strobe.
- stp_chk_en  out  1  one-cycle stop-check strobe.
- data_valid  out  1  one-cycle frame-good pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: synchronous, active-high. On the clk edge with rst=1: state to IDLE; all outputs 0 the next cycle. This applies mid-frame with no flush or partial pulse.
- Latched values:
  - pscl_q: prescale captured on the IDLE→START transition. Changes to prescale mid-frame are ignored.
  - par_en_q: par_en captured the same way.
- Derived values, from pscl_q:
  - mid = pscl_q>>1.
  - last = (edge_cnt == pscl_q+1): final edge of a bit; the counter wraps and increments bit_cnt on the following edge.
  - chk = (edge_cnt == mid+2).
- Sampler window: dat_samp_en = cnt_en AND (edge_cnt in {mid-1, mid, mid+1}).
- All outputs are registered (Moore); each strobe is high for exactly 1 cycle.
- IDLE:
  - cnt_en=0.
  - rx_in==0 → START.
- START:
  - cnt_en=1.
  - strt_chk_en on chk.
  - On last: strt_glitch=1 → IDLE (counter cleared); otherwise → DATA.
- DATA:
  - deser_en on chk.
  - On last with bit_cnt==DATA_BITS → PARITY if par_en_q, else STOP.
- PARITY:
  - par_chk_en on chk.
  - On last → STOP.
- STOP:
  - stp_chk_en on chk.
  - On last → CHECK.
- CHECK (1 cycle):
  - cnt_en=0.
  - data_valid = !stp_err && !(par_en_q && par_err).
  - Next state: rx_in==0 → START (back-to-back frame, no idle cycle lost); otherwise → IDLE.
- Error handling: frame errors never lock up the block. A bad frame drops data_valid and returns to IDLE/START normally.
- rx_in is ignored outside IDLE and CHECK.
- bit_cnt above the expected maximum (counter fault) forces → IDLE on the next last.
- Illegal prescale: odd or <4 produces an undefined sample position but bounded frame length; state must still return to IDLE.

Decomposition:
- Shared package uart_rx_pkg:
  - State enum {IDLE, START, DATA, PARITY, STOP, CHECK}, encoded 3 bits.
  - DATA_BITS.
  - Width constants.
- No sub-module.
- Companion top uart_rx_top instantiates this block, the edge/bit counter, sampler, deserializer and the three checkers.

Test Plan:
- prescale=8, par_en=0, frame 0xA5, clean stop: data_valid pulses once in CHECK; exactly 8 deser_en pulses, each at edge_cnt==6; busy low afterwards.
- prescale=8, par_en=1, even parity, 0x3C with correct parity: one par_chk_en; data_valid=1. Repeat with par_err forced 1: data_valid stays 0 and state returns to IDLE.
- rx_in low for 2 cycles then high: strt_glitch=1; FSM returns IDLE at the START last edge; no deser_en seen.
- Two frames back-to-back (start bit begins the cycle after the stop bit ends): CHECK→START directly; two data_valid pulses spaced exactly 10*(prescale+2)+1 cycles.
- rst asserted in DATA at bit_cnt==4: next cycle state=IDLE, cnt_en=0, busy=0; no data_valid; a subsequent clean frame 0xFF is received correctly.
- prescale changed from 8 to 16 mid-frame: current frame timing is unchanged (chk at edge 6); the next frame uses chk at edge 10.
